prog_loader: RTL and testbench

Boot-time program loader and instruction store for the 13-bit-instruction microcontroller core. It accepts a checksummed program image as a byte stream over a valid/ready handshake and writes it into a 256 × 13 program RAM. It holds the core in reset until the image verifies, then serves instructions to the core by asynchronous read on the core's `pc`. It sits directly upstream of the core: `inst` feeds the core's instruction input, and `core_reset` drives the core's `reset`.

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader_ram.sv | 26 ++
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader and its instruction store.
package prog_loader_pkg;

  localparam int INST_W = 13;
  localparam int PC_W   = 8;

  localparam logic [7:0] HI_PAD_MASK = 8'hE0;
  localparam logic [7:0] CHK_OK      = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/prog_loader_ram.sv
// Program store: one synchronous write port, one asynchronous read port.
// Contents survive reset so a partially loaded image is simply left in place.
module prog_ram #(
  parameter int DEPTH = 256,
  parameter int IW    = 13,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Streams a checksummed image into the program RAM and holds the core in reset
// until the image verifies; afterwards serves instructions on the core's pc.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW    = INST_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          reload,
  input  logic [7:0]    pc,
  output logic [IW-1:0] inst,
  output logic          core_reset,
  output logic          done,
  output logic          error
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HI_W = IW - 8;

  loader_state_e state_q, state_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    sum_q, sum_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic          in_ready_q, core_reset_q, done_q, error_q;

  logic          accept;
  logic          ramWe;
  logic [7:0]    sumNext;
  logic [IW-1:0] ramRdata;
  logic          pcInRange;
  logic          wrInRange;

  assign accept    = in_valid & in_ready_q;
  assign sumNext   = sum_q + in_data;
  assign wrInRange = ({1'b0, wr_addr_q} < 9'(DEPTH));
  assign pcInRange = ({1'b0, pc} < 9'(DEPTH));

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    count_d   = count_q;
    sum_d     = sum_q;
    hi_d      = hi_q;
    ramWe     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        count_d = in_data;
        sum_d   = sumNext;
        state_d = (in_data != 8'd0) ? ST_HI : ST_CHK;
      end
      ST_HI: if (accept) begin
        sum_d   = sumNext;
        hi_d    = in_data[HI_W-1:0];
        state_d = ((in_data & HI_PAD_MASK) == 8'd0) ? ST_LO : ST_ERR;
      end
      ST_LO: if (accept) begin
        sum_d     = sumNext;
        ramWe     = wrInRange;
        wr_addr_d = wr_addr_q + 8'd1;
        state_d   = (({1'b0, wr_addr_q} + 9'd1) < {1'b0, count_q}) ? ST_HI : ST_CHK;
      end
      ST_CHK: if (accept) begin
        sum_d   = sumNext;
        state_d = (sumNext == CHK_OK) ? ST_RUN : ST_ERR;
      end
      ST_RUN, ST_ERR: if (reload) begin
        // Re-entering IDLE restarts the image from address 0 with a clean sum.
        state_d   = ST_IDLE;
        wr_addr_d = 8'd0;
        sum_d     = 8'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= 8'd0;
      count_q      <= 8'd0;
      sum_q        <= 8'd0;
      hi_q         <= '0;
      in_ready_q   <= 1'b1;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      count_q      <= count_d;
      sum_q        <= sum_d;
      hi_q         <= hi_d;
      in_ready_q   <= (state_d != ST_RUN) && (state_d != ST_ERR);
      core_reset_q <= (state_d != ST_RUN);
      done_q       <= (state_d == ST_RUN);
      error_q      <= (state_d == ST_ERR);
    end
  end

  prog_ram #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ramWe),
    .waddr_i (wr_addr_q[AW-1:0]),
    .wdata_i ({hi_q, in_data}),
    .raddr_i (pc[AW-1:0]),
    .rdata_o (ramRdata)
  );

  assign inst       = pcInRange ? ramRdata : '0;
  assign in_ready   = in_ready_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: streams hand-built images and compares the
// handshake, status outputs and RAM read-back against hand-computed values.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic [7:0]  pc;
  logic [12:0] inst;
  logic        core_reset;
  logic        done;
  logic        error;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] imgBuf [0:15];
  int         imgLen;
  int         accepted;

  prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .reload     (reload),
    .pc         (pc),
    .inst       (inst),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives imgBuf[0..imgLen-1]; optional idle bubbles on odd cycles and a
  // three-cycle window in which the source sees no room and withholds data.
  task automatic applyStimulus(input bit bubbles, input int stallAt);
    int idx = 0;
    int cyc = 0;
    bit present;
    bit take;
    accepted = 0;
    while (idx < imgLen && cyc < 200) begin
      present  = !(bubbles && (cyc % 2 == 1)) && !(cyc >= stallAt && cyc < stallAt + 3);
      in_valid = present;
      in_data  = present ? imgBuf[idx] : 8'hA5;
      @(negedge clk);
      take = present && in_ready;
      @(posedge clk);
      #1;
      if (take) begin
        idx++;
        accepted++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (idx < imgLen) checkOutput("streamTimeout", idx, imgLen);
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic checkInst(input string tag, input logic [7:0] addr, input logic [12:0] exp);
    pc = addr;
    #1;
    checkOutput(tag, inst, exp);
  endtask

  task automatic loadImageA(input logic [7:0] chk);
    imgBuf[0] = 8'h03; imgBuf[1] = 8'h01; imgBuf[2] = 8'h00; imgBuf[3] = 8'h19;
    imgBuf[4] = 8'h01; imgBuf[5] = 8'h06; imgBuf[6] = 8'h04; imgBuf[7] = chk;
    imgLen = 8;
  endtask

  task automatic checkRunState(input string tag);
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_coreReset"}, core_reset, 0);
    checkOutput({tag, "_error"}, error, 0);
    checkOutput({tag, "_inReady"}, in_ready, 0);
  endtask

  task automatic checkImageA(input string tag);
    checkInst({tag, "_pc0"}, 8'd0, 13'h0100);
    checkInst({tag, "_pc1"}, 8'd1, 13'h1901);
    checkInst({tag, "_pc2"}, 8'd2, 13'h0604);
  endtask

  initial begin
    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    reload   = 1'b0;
    pc       = 8'h00;
    #23;
    checkOutput("rst_inReady", in_ready, 1);
    checkOutput("rst_coreReset", core_reset, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Image A at one byte per cycle; check just before and just after the checksum edge.
    loadImageA(8'hD8);
    imgLen = 7;
    applyStimulus(1'b0, 1000);
    checkOutput("a_preDone", done, 0);
    checkOutput("a_preCoreReset", core_reset, 1);
    imgBuf[0] = 8'hD8;
    imgLen = 1;
    applyStimulus(1'b0, 1000);
    checkRunState("a");
    checkImageA("a");

    // Overwrite with a different image so the throttled load has to rewrite A.
    pulseReload();
    imgBuf[0] = 8'h03; imgBuf[1] = 8'h00; imgBuf[2] = 8'h11; imgBuf[3] = 8'h00;
    imgBuf[4] = 8'h22; imgBuf[5] = 8'h00; imgBuf[6] = 8'h33; imgBuf[7] = 8'h97;
    imgLen = 8;
    applyStimulus(1'b0, 1000);
    checkRunState("c");
    checkInst("c_pc0", 8'd0, 13'h0011);
    checkInst("c_pc2", 8'd2, 13'h0033);

    // Throttled source: bubbles every other cycle plus a three-cycle stall.
    pulseReload();
    loadImageA(8'hD8);
    applyStimulus(1'b1, 4);
    checkOutput("b_accepted", accepted, 8);
    checkRunState("b");
    checkImageA("b");

    // Bad checksum.
    pulseReload();
    loadImageA(8'hD7);
    applyStimulus(1'b0, 1000);
    checkOutput("bad_error", error, 1);
    checkOutput("bad_done", done, 0);
    checkOutput("bad_coreReset", core_reset, 1);
    checkOutput("bad_inReady", in_ready, 0);

    // Reload together with a byte in ERR: the byte must not count as the next image's count.
    in_valid = 1'b1;
    in_data  = 8'h05;
    pulseReload();
    in_valid = 1'b0;
    checkOutput("rl_inReady", in_ready, 1);
    checkOutput("rl_error", error, 0);
    checkOutput("rl_coreReset", core_reset, 1);
    loadImageA(8'hD8);
    applyStimulus(1'b0, 1000);
    checkRunState("rl");

    // Nonzero pad bits in a HI byte.
    pulseReload();
    imgBuf[0] = 8'h01; imgBuf[1] = 8'h21;
    imgLen = 2;
    applyStimulus(1'b0, 1000);
    checkOutput("pad_error", error, 1);
    checkOutput("pad_done", done, 0);
    checkInst("pad_pc0", 8'd0, 13'h0100);

    // Empty image.
    pulseReload();
    imgBuf[0] = 8'h00; imgBuf[1] = 8'h00;
    imgLen = 2;
    applyStimulus(1'b0, 1000);
    checkRunState("empty");
    checkInst("empty_pc0", 8'd0, 13'h0100);

    // Reset after three bytes of image C, then a full load of A.
    pulseReload();
    imgBuf[0] = 8'h03; imgBuf[1] = 8'h00; imgBuf[2] = 8'h11;
    imgLen = 3;
    applyStimulus(1'b0, 1000);
    reset = 1'b1;
    #2;
    checkOutput("mid_inReady", in_ready, 1);
    checkOutput("mid_coreReset", core_reset, 1);
    checkOutput("mid_done", done, 0);
    reset = 1'b0;
    checkInst("mid_partial_pc0", 8'd0, 13'h0011);
    @(posedge clk);
    #1;
    loadImageA(8'hD8);
    applyStimulus(1'b0, 1000);
    checkRunState("post");
    checkImageA("post");

    pulseReload();
    checkOutput("rlRun_coreReset", core_reset, 1);
    checkOutput("rlRun_done", done, 0);
    checkOutput("rlRun_inReady", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
